// File: rtl/ram_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_access_ctrl_pkg
//  Description : Shared fill-FSM state encoding and RAM data width for the
//                RAM access controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_access_ctrl_pkg;

    localparam int RAM_DATA_W = 32;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } fill_state_e;

endpackage : ram_access_ctrl_pkg
`default_nettype wire

// File: rtl/ram_access_ctrl_resp_buf.sv
`default_nettype none
// ============================================================================
//  Module      : ram_resp_buf
//  Description : 2-entry synchronous FIFO holding read responses; the head
//                entry is a register so the output data is registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_resp_buf
    import ram_access_ctrl_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push_i,
    input  logic [RAM_DATA_W-1:0] data_i,
    input  logic                  pop_i,
    output logic [RAM_DATA_W-1:0] data_o,
    output logic                  valid_o,
    output logic [1:0]            count_o
);

    logic [RAM_DATA_W-1:0] head_q, head_d;
    logic [RAM_DATA_W-1:0] tail_q, tail_d;
    logic [1:0]            count_q, count_d;
    logic                  pop_ok;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_ok  = pop_i && (count_q != 2'd0);
        case ({push_i, pop_ok})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = data_i;
                end else begin
                    tail_d = data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                tail_d  = '0;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push and pop keeps occupancy constant.
                if (count_q == 2'd1) begin
                    head_d = data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = data_i;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign data_o  = head_q;
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule : ram_resp_buf
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_access_ctrl
//  Description : Arbitrates single-word reads and burst fills onto a RAM with
//                separate read/write ports; reads return via a 2-entry buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RREQ_VALID,
    output logic                  RREQ_READY,
    input  logic [WIDTH-1:0]      RREQ_ADDR,
    output logic                  RRESP_VALID,
    input  logic                  RRESP_READY,
    output logic [RAM_DATA_W-1:0] RRESP_DATA,
    input  logic                  FILL_START,
    input  logic [WIDTH-1:0]      FILL_ADDR,
    input  logic [WIDTH-1:0]      FILL_LEN,
    input  logic                  FILL_VALID,
    output logic                  FILL_READY,
    input  logic [RAM_DATA_W-1:0] FILL_DATA,
    output logic                  FILL_BUSY,
    output logic                  FILL_DONE,
    output logic                  RAM_RDEN,
    output logic [WIDTH-1:0]      RAM_RADDR,
    input  logic [RAM_DATA_W-1:0] RAM_RDATA,
    output logic                  RAM_WREN,
    output logic [WIDTH-1:0]      RAM_WADDR,
    output logic [RAM_DATA_W-1:0] RAM_WDATA
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    fill_state_e      state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             inflight_q;
    logic             wr_beat;
    logic             rd_accept;
    logic             resp_pop;
    logic [1:0]       buf_count;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wr_beat = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (FILL_START) begin
                    state_d = S_FILL;
                    addr_d  = FILL_ADDR;
                    cnt_d   = FILL_LEN;
                end
            end
            S_FILL: begin
                // Beats are held off during a reset cycle so nothing reaches the RAM.
                if (FILL_VALID && RST) begin
                    wr_beat = 1'b1;
                    addr_d  = addr_q + C_ONE;
                    cnt_d   = cnt_q - C_ONE;
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            inflight_q <= rd_accept;
        end
    end

    // Credit check: occupancy plus the read in flight must leave room, unless
    // the consumer drains an entry this same cycle.
    assign resp_pop   = RRESP_VALID && RRESP_READY;
    assign RREQ_READY = RST && (state_q == S_IDLE) && !FILL_START &&
                        ((({1'b0, buf_count} + {2'b00, inflight_q}) < 3'd2) || resp_pop);
    assign rd_accept  = RREQ_READY && RREQ_VALID;

    assign RAM_RDEN   = rd_accept;
    assign RAM_RADDR  = rd_accept ? RREQ_ADDR : '0;
    assign RAM_WREN   = wr_beat;
    assign RAM_WADDR  = wr_beat ? addr_q : '0;
    assign RAM_WDATA  = wr_beat ? FILL_DATA : '0;

    assign FILL_READY = (state_q == S_FILL);
    assign FILL_BUSY  = (state_q == S_FILL);
    assign FILL_DONE  = done_q;

    ram_resp_buf u_resp_buf (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (inflight_q),
        .data_i  (RAM_RDATA),
        .pop_i   (resp_pop),
        .data_o  (RRESP_DATA),
        .valid_o (RRESP_VALID),
        .count_o (buf_count)
    );

endmodule : ram_access_ctrl
`default_nettype wire
